// File: rtl/matrix_gen_arbiter.sv
// Two-requester round-robin arbiter for a shared random matrix generator.
// Each requester owns one pending job; the winner's config drives the generator until the next grant.
module matrix_gen_arbiter #(
  parameter int WIDTH       = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       row0,
  input  logic [2:0]       col0,
  input  logic [2:0]       row1,
  input  logic [2:0]       col1,
  input  logic [WIDTH-1:0] min0,
  input  logic [WIDTH-1:0] max0,
  input  logic [WIDTH-1:0] min1,
  input  logic [WIDTH-1:0] max1,
  output logic [2:0]       gen_row,
  output logic [2:0]       gen_col,
  output logic [WIDTH-1:0] gen_min,
  output logic [WIDTH-1:0] gen_max,
  output logic             gen_update_en,
  input  logic             gen_update_done,
  output logic [1:0]       grant,
  output logic             ack0,
  output logic             ack1,
  output logic             ack_err,
  output logic             busy,
  output logic             err_sticky
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  typedef struct packed {
    logic [2:0]       row;
    logic [2:0]       col;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } cfg_t;

  state_t     state, state_nxt;
  cfg_t       cfg0, cfg1;
  logic       pend0, pend1;
  logic       ptr;        // 1 means requester 1 wins the next tie
  logic       timed_out;
  logic [7:0] cnt;
  logic       win0;
  logic       tmo_hit;

  assign gen_update_en = (state == ISSUE);
  assign busy          = (state != IDLE);
  assign ack0          = (state == ACK) && grant[0];
  assign ack1          = (state == ACK) && grant[1];
  assign ack_err       = (state == ACK) && timed_out;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    win0      = pend0 && (!pend1 || !ptr);
    tmo_hit   = (cnt == 8'(TIMEOUT_CYC - 1));
    case (state)
      IDLE:    if (pend0 || pend1) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (gen_update_done || tmo_hit) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A new request on the acknowledging edge wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
      cfg0  <= '0;
      cfg1  <= '0;
    end else begin
      if (req0) begin
        pend0 <= 1'b1;
        cfg0  <= '{row: row0, col: col0, lo: min0, hi: max0};
      end else if (ack0) begin
        pend0 <= 1'b0;
      end
      if (req1) begin
        pend1 <= 1'b1;
        cfg1  <= '{row: row1, col: col1, lo: min1, hi: max1};
      end else if (ack1) begin
        pend1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= 2'b00;
      gen_row    <= 3'd1;
      gen_col    <= 3'd1;
      gen_min    <= '0;
      gen_max    <= '1;
      ptr        <= 1'b0;
      cnt        <= '0;
      timed_out  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            grant <= win0 ? 2'b01 : 2'b10;
            {gen_row, gen_col, gen_min, gen_max} <= win0 ? cfg0 : cfg1;
          end
        end
        ISSUE: begin
          cnt       <= '0;
          timed_out <= 1'b0;
        end
        WAIT: begin
          if (!gen_update_done) begin
            if (tmo_hit) timed_out <= 1'b1;
            else         cnt       <= cnt + 8'd1;
          end
        end
        ACK: begin
          grant <= 2'b00;
          ptr   <= grant[0];
          if (timed_out) err_sticky <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_gen_arbiter.sv
// Scoreboard bench for matrix_gen_arbiter: stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_matrix_gen_arbiter;

  localparam int WIDTH = 8;
  localparam int TO    = 64;

  typedef struct packed {
    logic [2:0]       row;
    logic [2:0]       col;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
  } cfg_t;

  typedef struct {
    logic who;
    logic err;
    cfg_t cfg;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [2:0]       row0 = '0, col0 = '0, row1 = '0, col1 = '0;
  logic [WIDTH-1:0] min0 = '0, max0 = '0, min1 = '0, max1 = '0;
  logic [2:0]       gen_row, gen_col;
  logic [WIDTH-1:0] gen_min, gen_max;
  logic             gen_update_en;
  logic             gen_update_done = 1'b0;
  logic [1:0]       grant;
  logic             ack0, ack1, ack_err, busy, err_sticky;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   cyc = 0, en_count = 0, ack_count = 0, last_en_cyc = 0, req_cyc = 0;
  int   stub_delay = 26, stub_cnt = 0;

  matrix_gen_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .row0(row0), .col0(col0), .row1(row1), .col1(col1),
    .min0(min0), .max0(max0), .min1(min1), .max1(max1),
    .gen_row(gen_row), .gen_col(gen_col), .gen_min(gen_min), .gen_max(gen_max),
    .gen_update_en(gen_update_en), .gen_update_done(gen_update_done),
    .grant(grant), .ack0(ack0), .ack1(ack1), .ack_err(ack_err),
    .busy(busy), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Generator stub: clears done on update_en, raises it stub_delay edges later (never when 0).
  always @(posedge clk) begin
    if (gen_update_en) begin
      gen_update_done <= 1'b0;
      stub_cnt        <= stub_delay;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) gen_update_done <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (gen_update_en === 1'b1) begin
      en_count++;
      last_en_cyc = cyc;
    end
    if (ack0 || ack1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_who", {30'd0, ack1, ack0}, mon_e.who ? 32'd2 : 32'd1);
        check("grant",   {30'd0, grant},      mon_e.who ? 32'd2 : 32'd1);
        check("ack_err", {31'd0, ack_err},    {31'd0, mon_e.err});
        check("gen_row", {29'd0, gen_row},    {29'd0, mon_e.cfg.row});
        check("gen_col", {29'd0, gen_col},    {29'd0, mon_e.cfg.col});
        check("gen_min", {24'd0, gen_min},    {24'd0, mon_e.cfg.lo});
        check("gen_max", {24'd0, gen_max},    {24'd0, mon_e.cfg.hi});
        if (mon_e.err) check("timeout_latency", cyc - last_en_cyc, TO + 1);
      end
      ack_count++;
    end
  end

  function automatic cfg_t mk(input int r, input int c, input int lo, input int hi);
    mk = '{row: 3'(r), col: 3'(c), lo: WIDTH'(lo), hi: WIDTH'(hi)};
  endfunction

  task automatic issue(input logic r0, input logic r1, input cfg_t c0, input cfg_t c1,
                       input logic err, input logic expect_it);
    @(posedge clk); #1;
    req0 = r0; req1 = r1;
    {row0, col0, min0, max0} = c0;
    {row1, col1, min1, max1} = c1;
    req_cyc = cyc;
    if (expect_it && r0) exp_q.push_back('{1'b0, err, c0});
    if (expect_it && r1) exp_q.push_back('{1'b1, err, c1});
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget);
    for (int i = 0; i < budget && ack_count < target; i++) @(negedge clk);
    check("ack_arrived", (ack_count >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_reset_values();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_en", {31'd0, gen_update_en}, 32'd0);
    check("rst_acks", {29'd0, ack0, ack1, ack_err}, 32'd0);
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    check("rst_gen", {18'd0, gen_row, gen_col, gen_min}, {18'd0, 3'd1, 3'd1, 8'd0});
    check("rst_gen_max", {24'd0, gen_max}, 32'hff);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int base;
    cfg_t z;
    z = mk(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_reset_values();
    rst = 1'b0;

    // Single job with a slow generator.
    base = en_count;
    issue(1'b1, 1'b0, mk(3, 4, 10, 20), z, 1'b0, 1'b1);
    wait_acks(1, 200);
    check("single_en_count", en_count - base, 1);
    check("en_latency", last_en_cyc - req_cyc, 2);
    check("single_err_sticky", {31'd0, err_sticky}, 32'd0);

    // Simultaneous requests right after reset: 0 then 1.
    do_reset();
    stub_delay = 5;
    base = en_count;
    issue(1'b1, 1'b1, mk(2, 5, 1, 99), mk(7, 6, 40, 200), 1'b0, 1'b1);
    wait_acks(3, 200);
    check("tie_en_count", en_count - base, 2);

    // Back-to-back: each acked requester re-requests immediately, so grants alternate.
    stub_delay = 3;
    issue(1'b1, 1'b1, mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_acks(4 + i, 200);
      if (i % 2 == 0) issue(1'b1, 1'b0, mk(i, i + 1, 16 * i, 255 - i), z, 1'b0, 1'b1);
      else            issue(1'b0, 1'b1, z, mk(7 - i, i, 8 * i, 128 + i), 1'b0, 1'b1);
    end
    wait_acks(10, 200);

    // Generator never completes: timed-out ack, then a normal job.
    stub_delay = 0;
    issue(1'b0, 1'b1, z, mk(4, 4, 0, 255), 1'b1, 1'b1);
    wait_acks(11, TO + 40);
    repeat (2) @(negedge clk);
    check("timeout_err_sticky", {31'd0, err_sticky}, 32'd1);
    stub_delay = 4;
    issue(1'b1, 1'b0, mk(6, 1, 9, 11), z, 1'b0, 1'b1);
    wait_acks(12, 200);
    check("post_timeout_sticky", {31'd0, err_sticky}, 32'd1);

    // Reset in the middle of WAIT drops both jobs, and requests during reset.
    stub_delay = 0;
    base = en_count;
    issue(1'b1, 1'b1, mk(3, 3, 3, 3), mk(5, 5, 5, 5), 1'b0, 1'b0);
    for (int i = 0; i < 50 && en_count == base; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("midwait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1 check_reset_values();
    exp_q.delete();
    @(posedge clk); #1 req1 = 1'b1;
    @(posedge clk); #1 req1 = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("after_rst_idle", {31'd0, busy}, 32'd0);
    stub_delay = 4;
    issue(1'b1, 1'b0, mk(2, 7, 12, 34), z, 1'b0, 1'b1);
    wait_acks(13, 200);

    // req0 on the same edge as ack0 keeps one job pending.
    stub_delay = 3;
    base = en_count;
    issue(1'b1, 1'b0, mk(1, 1, 50, 60), z, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack0) begin
        req0 = 1'b1;
        {row0, col0, min0, max0} = mk(5, 3, 70, 80);
        exp_q.push_back('{1'b0, 1'b0, mk(5, 3, 70, 80)});
        @(posedge clk); #1 req0 = 1'b0;
        break;
      end
    end
    wait_acks(15, 200);
    check("reack_en_count", en_count - base, 2);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
